// File: rtl/div_unit_pkg.sv
// Shared RV32M divide definitions: OP encodings (funct3[1:0]), FSM state encodings and XLEN.
// No logic of its own; imported by the divider top and its iteration step.
package div_unit_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   function automatic logic is_signed_op(input op_e op);
      return ~op[0];
   endfunction

   function automatic logic is_rem_op(input op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left, trial-subtract the divisor.
// Purely combinational, zero latency; no flow control.
module div_unit_step
   import div_unit_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH:0]   o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_trial;

   assign w_shift = {i_rem, i_quo[WIDTH-1]};
   assign w_trial = w_shift - {2'b00, i_div};

   // A set top bit means the trial went negative: restore and shift in a 0.
   assign o_rem = w_trial[WIDTH+1] ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
   assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH+1]};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU: 34 edges START-to-DONE (1 for div-by-zero/overflow).
// BUSY stalls the pipeline during CALC/FIX; START only accepted in IDLE/DONE; FLUSH aborts.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [1:0]       OP,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   input  logic             FLUSH,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT
);

   localparam int CW = $clog2(WIDTH);

   state_e           r_state, w_state_n;
   op_e              r_op, w_op;
   logic             r_sign1, r_sign2;
   logic [WIDTH:0]   r_rem, w_rem_n;
   logic [WIDTH-1:0] r_quo, w_quo_n, r_div, r_result;
   logic [CW-1:0]    r_cnt;

   logic             w_sign1, w_sign2, w_div0, w_ovf, w_special, w_accept;
   logic [WIDTH-1:0] w_abs1, w_abs2, w_special_res, w_quo_fix, w_rem_fix;

   assign w_op    = op_e'(OP);
   assign w_sign1 = is_signed_op(w_op) & DATA1[WIDTH-1];
   assign w_sign2 = is_signed_op(w_op) & DATA2[WIDTH-1];
   assign w_abs1  = w_sign1 ? -DATA1 : DATA1;
   assign w_abs2  = w_sign2 ? -DATA2 : DATA2;

   // Architecturally defined results that bypass the iteration entirely.
   assign w_div0    = (DATA2 == '0);
   assign w_ovf     = is_signed_op(w_op) && (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);
   assign w_special = w_div0 | w_ovf;
   assign w_special_res = w_div0 ? (is_rem_op(w_op) ? DATA1 : '1)
                                 : (is_rem_op(w_op) ? '0 : DATA1);

   assign w_accept  = ((r_state == S_IDLE) || (r_state == S_DONE)) && START && !FLUSH;

   assign w_quo_fix = ((r_op == OP_DIV) && (r_sign1 ^ r_sign2)) ? -r_quo : r_quo;
   assign w_rem_fix = ((r_op == OP_REM) && r_sign1) ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

   div_unit_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_div (r_div),
      .o_rem (w_rem_n),
      .o_quo (w_quo_n)
   );

   always_comb begin
      w_state_n = r_state;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      case (r_state)
         S_IDLE: if (START) w_state_n = w_special ? S_DONE : S_CALC;
         S_CALC: begin
            BUSY = 1'b1;
            if (r_cnt == '0) w_state_n = S_FIX;
         end
         S_FIX: begin
            BUSY      = 1'b1;
            w_state_n = S_DONE;
         end
         S_DONE: begin
            DONE      = 1'b1;
            w_state_n = START ? (w_special ? S_DONE : S_CALC) : S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
      if (FLUSH) w_state_n = S_IDLE;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state  <= S_IDLE;
         r_op     <= OP_DIV;
         r_sign1  <= 1'b0;
         r_sign2  <= 1'b0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_n;
         if (w_accept) begin
            r_op    <= w_op;
            r_sign1 <= w_sign1;
            r_sign2 <= w_sign2;
            r_rem   <= '0;
            r_quo   <= w_abs1;
            r_div   <= w_abs2;
            r_cnt   <= CW'(WIDTH - 1);
            if (w_special) r_result <= w_special_res;
         end else if ((r_state == S_CALC) && !FLUSH) begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
         end else if ((r_state == S_FIX) && !FLUSH) begin
            r_result <= is_rem_op(r_op) ? w_rem_fix : w_quo_fix;
         end
      end
   end

   assign RESULT = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Scenario-driven bench for div_unit: expected results are queued when an operation is issued
// and popped when DONE is observed; outputs are sampled on the falling clock edge.
module tb_div_unit;
   import div_unit_pkg::*;

   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         RESET = 1'b0;
   logic         START = 1'b0;
   logic         FLUSH = 1'b0;
   logic [1:0]   OP = 2'b00;
   logic [W-1:0] DATA1 = '0;
   logic [W-1:0] DATA2 = '0;
   logic         BUSY, DONE;
   logic [W-1:0] RESULT;

   int           checks = 0;
   int           failures = 0;
   logic [W-1:0] sb[$];

   div_unit #(.WIDTH(W)) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .START  (START),
      .OP     (OP),
      .DATA1  (DATA1),
      .DATA2  (DATA2),
      .FLUSH  (FLUSH),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .RESULT (RESULT)
   );

   always #5 CLK = ~CLK;

   // Drive a request (caller is positioned at a falling edge) and optionally queue its result.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input bit push);
      START = 1'b1;
      OP    = op;
      DATA1 = a;
      DATA2 = b;
      if (push) sb.push_back(exp);
   endtask

   // Count edges and BUSY cycles until DONE is seen, bounded at 100 edges.
   task automatic wait_done(output int edges, output int busy, output bit got);
      edges = 0;
      busy  = 0;
      got   = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge CLK);
         edges++;
         @(negedge CLK);
         START = 1'b0;
         if (BUSY === 1'b1) busy++;
         if (DONE === 1'b1) got = 1'b1;
      end
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", BUSY); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", DONE); end
      checks++; if (RESULT !== '0) begin failures++; $display("FAIL reset_result got=%h want=0", RESULT); end
      RESET = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_divu_timing;
      int e, b; bit g; logic [W-1:0] exp;
      @(negedge CLK);
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
      wait_done(e, b, g);
      checks++; if (e !== 34) begin failures++; $display("FAIL divu_latency got=%0d want=34", e); end
      checks++; if (b !== 33) begin failures++; $display("FAIL divu_busy_cycles got=%0d want=33", b); end
      checks++;
      if (!g) begin
         failures++; $display("FAIL divu_timeout got=no_done want=done"); void'(sb.pop_front());
      end else begin
         exp = sb.pop_front();
         if (RESULT !== exp) begin failures++; $display("FAIL divu_result got=%h want=%h", RESULT, exp); end
      end
      @(negedge CLK);
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b want=0", DONE); end
      checks++; if (RESULT !== 32'd14) begin failures++; $display("FAIL result_hold got=%h want=0000000e", RESULT); end
   endtask

   task automatic test_signed;
      logic [1:0]   ops [0:6];
      logic [W-1:0] as  [0:6];
      logic [W-1:0] bs  [0:6];
      logic [W-1:0] es  [0:6];
      int e, b; bit g; logic [W-1:0] exp;
      ops = '{OP_DIV, OP_REM, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
      as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd20, 32'd20, 32'hFFFF_FFEC, 32'hFFFF_FFEC};
      bs  = '{32'd2, 32'd2, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
      es  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFA, 32'd2, 32'd6, 32'hFFFF_FFFE};
      for (int i = 0; i < 7; i++) begin
         @(negedge CLK);
         issue(ops[i], as[i], bs[i], es[i], 1'b1);
         wait_done(e, b, g);
         checks++;
         if (!g) begin
            failures++; $display("FAIL signed_%0d_timeout got=no_done want=done", i); void'(sb.pop_front());
         end else begin
            exp = sb.pop_front();
            if (RESULT !== exp) begin failures++; $display("FAIL signed_%0d_result got=%h want=%h", i, RESULT, exp); end
         end
      end
   endtask

   task automatic test_random_unsigned;
      int e, b; bit g; logic [W-1:0] exp, a, d; logic [1:0] op;
      for (int i = 0; i < 4; i++) begin
         a  = $urandom;
         d  = $urandom_range(1, 65535);
         op = (i % 2 == 0) ? OP_DIVU : OP_REMU;
         @(negedge CLK);
         issue(op, a, d, (op == OP_DIVU) ? a / d : a % d, 1'b1);
         wait_done(e, b, g);
         checks++;
         if (!g) begin
            failures++; $display("FAIL rand_%0d_timeout got=no_done want=done", i); void'(sb.pop_front());
         end else begin
            exp = sb.pop_front();
            if (RESULT !== exp) begin failures++; $display("FAIL rand_%0d_result got=%h want=%h", i, RESULT, exp); end
         end
      end
   endtask

   task automatic test_special;
      logic [1:0]   ops [0:5];
      logic [W-1:0] as  [0:5];
      logic [W-1:0] bs  [0:5];
      logic [W-1:0] es  [0:5];
      int e, b; bit g; logic [W-1:0] exp;
      ops = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
      as  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'hFFFF_FFFD};
      bs  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
      es  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         issue(ops[i], as[i], bs[i], es[i], 1'b1);
         wait_done(e, b, g);
         checks++; if (e !== 1) begin failures++; $display("FAIL special_%0d_latency got=%0d want=1", i, e); end
         checks++; if (b !== 0) begin failures++; $display("FAIL special_%0d_busy got=%0d want=0", i, b); end
         checks++;
         if (!g) begin
            failures++; $display("FAIL special_%0d_timeout got=no_done want=done", i); void'(sb.pop_front());
         end else begin
            exp = sb.pop_front();
            if (RESULT !== exp) begin failures++; $display("FAIL special_%0d_result got=%h want=%h", i, RESULT, exp); end
         end
      end
   endtask

   task automatic test_flush;
      bit seen = 1'b0;
      // Last completed op in test_special left RESULT = 0xFFFFFFFD.
      @(negedge CLK);
      issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0);
      @(negedge CLK);
      START = 1'b0;
      repeat (9) @(negedge CLK);
      FLUSH = 1'b1;
      @(negedge CLK);
      FLUSH = 1'b0;
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b want=0", BUSY); end
      checks++; if (RESULT !== 32'hFFFF_FFFD) begin failures++; $display("FAIL flush_result got=%h want=fffffffd", RESULT); end
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (DONE === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%b want=0", seen); end
   endtask

   task automatic test_start_ignored;
      int e, b; bit g; logic [W-1:0] exp;
      @(negedge CLK);
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
      repeat (5) begin
         @(negedge CLK);
         START = 1'b0;
      end
      issue(OP_REMU, 32'd1000, 32'd3, 32'd0, 1'b0);
      wait_done(e, b, g);
      checks++;
      if (!g) begin
         failures++; $display("FAIL ignore_timeout got=no_done want=done"); void'(sb.pop_front());
      end else begin
         exp = sb.pop_front();
         if (RESULT !== exp) begin failures++; $display("FAIL ignore_start_result got=%h want=%h", RESULT, exp); end
      end
      checks++; if (e !== 29) begin failures++; $display("FAIL ignore_start_latency got=%0d want=29", e); end
   endtask

   task automatic test_reset_mid_calc;
      @(negedge CLK);
      issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0);
      repeat (10) begin
         @(negedge CLK);
         START = 1'b0;
      end
      #2 RESET = 1'b1;
      #1;
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b want=0", BUSY); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL async_reset_done got=%b want=0", DONE); end
      checks++; if (RESULT !== '0) begin failures++; $display("FAIL async_reset_result got=%h want=0", RESULT); end
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic test_back_to_back;
      int e, b; bit g; logic [W-1:0] exp;
      @(negedge CLK);
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1);
      wait_done(e, b, g);
      checks++;
      if (!g) begin
         failures++; $display("FAIL b2b_first_timeout got=no_done want=done"); void'(sb.pop_front());
      end else begin
         exp = sb.pop_front();
         if (RESULT !== exp) begin failures++; $display("FAIL b2b_first_result got=%h want=%h", RESULT, exp); end
      end
      issue(OP_REM, 32'd9, 32'd4, 32'd1, 1'b1);
      wait_done(e, b, g);
      checks++; if (e !== 34) begin failures++; $display("FAIL b2b_latency got=%0d want=34", e); end
      checks++;
      if (!g) begin
         failures++; $display("FAIL b2b_second_timeout got=no_done want=done"); void'(sb.pop_front());
      end else begin
         exp = sb.pop_front();
         if (RESULT !== exp) begin failures++; $display("FAIL b2b_second_result got=%h want=%h", RESULT, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_divu_timing();
      test_signed();
      test_random_unsigned();
      test_special();
      test_flush();
      test_start_ignored();
      test_reset_mid_calc();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
